// File: rtl/sanmoku_player.sv
// User-side tic-tac-toe player: tracks the board, accepts machine (o) moves and
// offers its own (x) move chosen as win, else block, else first free cell in preference order.
module sanmoku_player (
   input  logic       CLK,
   input  logic       RST,
   input  logic       m_valid,
   input  logic [3:0] m_cell,
   output logic       m_ready,
   output logic       u_valid,
   output logic [3:0] u_cell,
   input  logic       u_ready,
   output logic [8:0] board_o,
   output logic [8:0] board_x,
   output logic       isNotEnd,
   output logic       userWins,
   output logic       machineWins
);

   localparam int unsigned CELLS  = 9;
   localparam int unsigned IDX_W  = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

   typedef enum logic [2:0] {WAIT_M, EVAL_M, SCAN, OFFER, EVAL_U, DONE} state_t;

   state_t state, next_state;

   logic [IDX_W-1:0] scan_idx;
   logic             win_found, blk_found, free_found;
   logic [IDX_W-1:0] win_cell, blk_cell, free_cell;

   function automatic logic has_line(input logic [CELLS-1:0] b);
      has_line = (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
                 (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
                 (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
   endfunction

   // Scan position -> cell: centre, corners, then edges.
   function automatic logic [IDX_W-1:0] pref_cell(input logic [IDX_W-1:0] idx);
      case (idx)
         4'd0:    pref_cell = 4'd4;
         4'd1:    pref_cell = 4'd0;
         4'd2:    pref_cell = 4'd2;
         4'd3:    pref_cell = 4'd6;
         4'd4:    pref_cell = 4'd8;
         4'd5:    pref_cell = 4'd1;
         4'd6:    pref_cell = 4'd3;
         4'd7:    pref_cell = 4'd5;
         default: pref_cell = 4'd7;
      endcase
   endfunction

   logic [CELLS-1:0] occupied, m_mask, scan_mask, u_mask;
   logic             m_fire, u_fire, m_bad, o_line, x_line, full;
   logic [IDX_W-1:0] scan_cell, choice;
   logic             scan_empty, scan_win, scan_blk, scan_last;
   logic             win_nx, blk_nx;
   logic [IDX_W-1:0] win_cell_nx, blk_cell_nx, free_cell_nx;

   always_comb begin
      occupied     = board_o | board_x;
      m_mask       = (m_cell < 4'd9) ? (9'd1 << m_cell) : 9'd0;
      u_mask       = (u_cell < 4'd9) ? (9'd1 << u_cell) : 9'd0;
      m_fire       = m_valid & m_ready;
      u_fire       = u_valid & u_ready;
      m_bad        = (m_mask == 9'd0) || ((occupied & m_mask) != 9'd0);
      o_line       = has_line(board_o);
      x_line       = has_line(board_x);
      full         = &occupied;
      scan_cell    = pref_cell(scan_idx);
      scan_mask    = 9'd1 << scan_cell;
      scan_empty   = (occupied & scan_mask) == 9'd0;
      scan_win     = scan_empty & has_line(board_x | scan_mask);
      scan_blk     = scan_empty & has_line(board_o | scan_mask);
      scan_last    = scan_idx == LAST_IDX;
      win_nx       = win_found | scan_win;
      blk_nx       = blk_found | scan_blk;
      win_cell_nx  = win_found  ? win_cell  : scan_cell;
      blk_cell_nx  = blk_found  ? blk_cell  : scan_cell;
      free_cell_nx = (free_found || !scan_empty) ? free_cell : scan_cell;
      choice       = win_nx ? win_cell_nx : (blk_nx ? blk_cell_nx : free_cell_nx);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= WAIT_M;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         WAIT_M:  if (m_fire) next_state = m_bad ? DONE : EVAL_M;
         EVAL_M:  next_state = (o_line || full) ? DONE : SCAN;
         SCAN:    if (scan_last) next_state = OFFER;
         OFFER:   if (u_fire) next_state = EVAL_U;
         EVAL_U:  next_state = (x_line || full) ? DONE : WAIT_M;
         default: next_state = DONE;
      endcase
   end

   // Handshake outputs depend on state only.
   always_comb begin
      m_ready = 1'b0;
      u_valid = 1'b0;
      case (state)
         WAIT_M:  m_ready = 1'b1;
         OFFER:   u_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         board_o     <= '0;
         board_x     <= '0;
         isNotEnd    <= 1'b1;
         userWins    <= 1'b0;
         machineWins <= 1'b0;
         u_cell      <= '0;
         scan_idx    <= '0;
         win_found   <= 1'b0;
         blk_found   <= 1'b0;
         free_found  <= 1'b0;
         win_cell    <= '0;
         blk_cell    <= '0;
         free_cell   <= '0;
      end else begin
         case (state)
            WAIT_M: begin
               if (m_fire) begin
                  if (m_bad) begin
                     userWins <= 1'b1;
                     isNotEnd <= 1'b0;
                  end else begin
                     board_o <= board_o | m_mask;
                  end
               end
            end
            EVAL_M: begin
               if (o_line) begin
                  machineWins <= 1'b1;
                  isNotEnd    <= 1'b0;
               end else if (full) begin
                  isNotEnd <= 1'b0;
               end
               scan_idx   <= '0;
               win_found  <= 1'b0;
               blk_found  <= 1'b0;
               free_found <= 1'b0;
            end
            SCAN: begin
               win_found  <= win_nx;
               blk_found  <= blk_nx;
               free_found <= free_found | scan_empty;
               win_cell   <= win_cell_nx;
               blk_cell   <= blk_cell_nx;
               free_cell  <= free_cell_nx;
               scan_idx   <= scan_idx + 4'd1;
               if (scan_last) u_cell <= choice;
            end
            OFFER: begin
               if (u_fire) board_x <= board_x | u_mask;
            end
            EVAL_U: begin
               if (x_line) begin
                  userWins <= 1'b1;
                  isNotEnd <= 1'b0;
               end else if (full) begin
                  isNotEnd <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sanmoku_player.sv
// Bench for sanmoku_player: game-level reference model with per-cycle output comparison,
// directed openings plus randomized games with illegal moves and backpressure.
module tb_sanmoku_player;

   logic       CLK, RST;
   logic       m_valid;
   logic [3:0] m_cell;
   logic       m_ready, u_valid, u_ready;
   logic [3:0] u_cell;
   logic [8:0] board_o, board_x;
   logic       isNotEnd, userWins, machineWins;

   sanmoku_player dut (
      .CLK(CLK), .RST(RST),
      .m_valid(m_valid), .m_cell(m_cell), .m_ready(m_ready),
      .u_valid(u_valid), .u_cell(u_cell), .u_ready(u_ready),
      .board_o(board_o), .board_x(board_x),
      .isNotEnd(isNotEnd), .userWins(userWins), .machineWins(machineWins)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   logic [8:0] exp_bo, exp_bx;
   bit         exp_ne, exp_uw, exp_mw, exp_mr, exp_uv;
   int         exp_uc;

   const int pref[9]     = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
   const int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   initial CLK = 0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit has_line(input logic [8:0] b);
      for (int l = 0; l < 8; l++)
         if (b[lines[l][0]] && b[lines[l][1]] && b[lines[l][2]]) return 1;
      return 0;
   endfunction

   // Policy: first winning cell, else first blocking cell, else first empty, all in preference order.
   function automatic int choose(input logic [8:0] bo, input logic [8:0] bx);
      logic [8:0] occ;
      logic [8:0] m;
      occ = bo | bx;
      for (int i = 0; i < 9; i++) begin
         m = 9'(1) << pref[i];
         if ((occ & m) == 0 && has_line(bx | m)) return pref[i];
      end
      for (int i = 0; i < 9; i++) begin
         m = 9'(1) << pref[i];
         if ((occ & m) == 0 && has_line(bo | m)) return pref[i];
      end
      for (int i = 0; i < 9; i++)
         if (!occ[pref[i]]) return pref[i];
      return -1;
   endfunction

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("board_o", int'(board_o), int'(exp_bo));
         chk("board_x", int'(board_x), int'(exp_bx));
         chk("isNotEnd", int'(isNotEnd), int'(exp_ne));
         chk("userWins", int'(userWins), int'(exp_uw));
         chk("machineWins", int'(machineWins), int'(exp_mw));
         chk("m_ready", int'(m_ready), int'(exp_mr));
         chk("u_valid", int'(u_valid), int'(exp_uv));
         if (exp_uv) chk("u_cell", int'(u_cell), exp_uc);
         chk("overlap", int'(board_o & board_x), 0);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic junk();
      m_valid = 1'($urandom_range(0, 1));
      m_cell  = 4'($urandom_range(0, 15));
      u_ready = 1'($urandom_range(0, 1));
   endtask

   // Asserts RST mid-cycle and checks the reset values before any clock edge.
   task automatic apply_reset();
      #2;
      RST = 1;
      m_valid = 0;
      u_ready = 0;
      #1;
      exp_bo = '0; exp_bx = '0; exp_ne = 1; exp_uw = 0; exp_mw = 0;
      exp_mr = 1; exp_uv = 0; exp_uc = 0;
      cmp_en = 1;
      chk("rst_board_o", int'(board_o), 0);
      chk("rst_board_x", int'(board_x), 0);
      chk("rst_u_valid", int'(u_valid), 0);
      chk("rst_m_ready", int'(m_ready), 1);
      chk("rst_isNotEnd", int'(isNotEnd), 1);
      chk("rst_flags", int'({userWins, machineWins}), 0);
      chk("rst_u_cell", int'(u_cell), 0);
      tick();
      RST = 0;
   endtask

   // One machine move followed by the user's reply. Called at posedge+1 with the DUT in WAIT_M.
   task automatic machine_move(input int c, input int hold, input bit rst_mid,
                               output bit ended, output int offered);
      int h;
      ended   = 0;
      offered = -1;
      repeat ($urandom_range(0, 2)) begin
         m_valid = 0;
         u_ready = 1'($urandom_range(0, 1));
         tick();
      end
      m_valid = 1;
      m_cell  = 4'(c);
      tick();
      junk();
      if (c > 8 || ((exp_bo | exp_bx) & (9'(1) << c)) != 0) begin
         exp_uw = 1; exp_ne = 0; exp_mr = 0;
         ended = 1;
         return;
      end
      exp_bo = exp_bo | (9'(1) << c);
      exp_mr = 0;
      tick();
      junk();
      if (has_line(exp_bo)) begin
         exp_mw = 1; exp_ne = 0; ended = 1;
         return;
      end
      if (&(exp_bo | exp_bx)) begin
         exp_ne = 0; ended = 1;
         return;
      end
      repeat (8) begin
         tick();
         junk();
      end
      tick();
      exp_uv  = 1;
      exp_uc  = choose(exp_bo, exp_bx);
      offered = int'(u_cell);
      h = (hold < 0) ? int'($urandom_range(0, 5)) : hold;
      junk();
      u_ready = 0;
      repeat (h) begin
         tick();
         junk();
         u_ready = 0;
      end
      if (rst_mid) begin
         apply_reset();
         ended = 1;
         return;
      end
      u_ready = 1;
      tick();
      junk();
      exp_bx = exp_bx | (9'(1) << exp_uc);
      exp_uv = 0;
      tick();
      if (has_line(exp_bx)) begin
         exp_uw = 1; exp_ne = 0; ended = 1;
      end else if (&(exp_bo | exp_bx)) begin
         exp_ne = 0; ended = 1;
      end else begin
         exp_mr = 1;
      end
      junk();
      if (!ended) m_valid = 0;
   endtask

   function automatic int pick_move();
      logic [8:0] occ;
      int c;
      occ = exp_bo | exp_bx;
      if ($urandom_range(0, 99) < 8) begin
         if ($urandom_range(0, 1) == 1 && occ != 0) begin
            do c = $urandom_range(0, 8); while (!occ[c]);
            return c;
         end
         return $urandom_range(9, 15);
      end
      do c = $urandom_range(0, 8); while (occ[c]);
      return c;
   endfunction

   initial begin
      bit ended;
      int off;
      RST = 0; m_valid = 0; m_cell = 0; u_ready = 0;
      tick();

      // Opening, then win taking priority over block
      apply_reset();
      machine_move(4, 0, 0, ended, off);
      chk("t1_offer", off, 0);
      chk("t1_board_o", int'(board_o), 'h010);
      chk("t1_board_x", int'(board_x), 'h001);
      chk("t1_isNotEnd", int'(isNotEnd), 1);
      machine_move(8, 0, 0, ended, off);
      chk("t2_free", off, 2);
      machine_move(6, 0, 0, ended, off);
      chk("t2_win", off, 1);
      chk("t2_userWins", int'(userWins), 1);
      chk("t2_isNotEnd", int'(isNotEnd), 0);
      chk("t2_m_ready", int'(m_ready), 0);
      repeat (4) begin tick(); junk(); end

      // Block
      apply_reset();
      machine_move(4, -1, 0, ended, off);
      machine_move(1, -1, 0, ended, off);
      chk("t3_block", off, 7);

      // Forfeit on occupied cell and on out-of-range cell
      for (int k = 0; k < 2; k++) begin
         apply_reset();
         machine_move(4, -1, 0, ended, off);
         machine_move((k == 0) ? 0 : 9, -1, 0, ended, off);
         chk("t4_userWins", int'(userWins), 1);
         chk("t4_isNotEnd", int'(isNotEnd), 0);
         chk("t4_u_valid", int'(u_valid), 0);
         repeat (15) begin tick(); junk(); end
      end

      // Backpressure for 5 cycles, then asynchronous reset during OFFER
      apply_reset();
      machine_move(4, 5, 1, ended, off);
      chk("t5_offer", off, 0);

      // Randomized games
      for (int g = 0; g < 60; g++) begin
         apply_reset();
         ended = 0;
         while (!ended) machine_move(pick_move(), -1, 0, ended, off);
         repeat ($urandom_range(2, 6)) begin tick(); junk(); end
      end

      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
